mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the address bus width and the width of the address mux output.
REQ-002 The block SHALL have parameter DATA_W, default 32, the memory data word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum number of ACCESS cycles waited for mem_ack.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have port req, input, 1, start a transaction when sampled high in IDLE.
REQ-007 The block SHALL have port we, input, 1, 1 = write, 0 = read; sampled with req.
REQ-008 The block SHALL have port addr, input, ADDR_W, transaction address driven by the address bus mux; sampled with req.
REQ-009 The block SHALL have port wdata, input, DATA_W, write data; sampled with req.
REQ-010 The block SHALL have port busy, output, 1, high in ACCESS and RESP.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1, timeout flag; valid only while done=1.
REQ-013 The block SHALL have port rdata, output, DATA_W, last successfully read word.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W, latched address to memory.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W, latched write data to memory.
REQ-016 The block SHALL have port mem_rd, output, 1, read strobe.
REQ-017 The block SHALL have port mem_wr, output, 1, write strobe.
REQ-018 The block SHALL have port mem_rdata, input, DATA_W, memory read data; valid when mem_ack=1.
REQ-019 The block SHALL have port mem_ack, input, 1, memory completion.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-021 In IDLE with req=1, the block SHALL latch addr, we and wdata into mem_addr, an internal we register and mem_wdata, clear the wait counter, and enter ACCESS on the next edge.
REQ-022 In IDLE with req=0, the block SHALL remain in IDLE with all registered outputs held.
REQ-023 In ACCESS, mem_rd SHALL equal the negation of the latched we and mem_wr SHALL equal the latched we; both strobes SHALL be 0 in IDLE and RESP.
REQ-024 In ACCESS with mem_ack=1, the block SHALL enter RESP; on a read it SHALL capture mem_rdata into rdata on the same edge; on a write rdata SHALL be unchanged.
REQ-025 In ACCESS with mem_ack=0, the block SHALL increment the wait counter; when the counter reaches TIMEOUT-1 and mem_ack=0, it SHALL enter RESP with timeout flagged, and rdata SHALL be unchanged.
REQ-026 When mem_ack=1 on the final permitted ACCESS cycle, it SHALL count as success (ack wins over timeout).
REQ-027 In RESP, done SHALL be 1 for exactly one cycle, err SHALL be 1 only on a timed-out transaction, and the block SHALL return to IDLE on the next edge.
REQ-028 Minimum latency SHALL be: req sampled at edge N, ACCESS during cycle N+1, done high during cycle N+2 if mem_ack=1 in the first ACCESS cycle.
REQ-029 A timed-out transaction SHALL spend exactly TIMEOUT cycles in ACCESS, so that done is high during cycle N+1+TIMEOUT.
REQ-030 req asserted while busy=1 SHALL be ignored, with no queuing.
REQ-031 mem_ack asserted in IDLE or RESP SHALL be ignored.
REQ-032 Addresses SHALL pass through unmodified, including 0xFFFF, with no increment or wrap.
REQ-033 A back-to-back req presented during the RESP cycle SHALL be ignored; req SHALL be accepted only in IDLE, so the earliest next acceptance edge is the edge ending the first IDLE cycle.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL enter IDLE and set busy, done, err, mem_rd and mem_wr to 0, and mem_addr, mem_wdata, rdata and the wait counter to 0.
REQ-035 When reset is applied mid-ACCESS, the strobes SHALL drop at that edge and no done pulse SHALL be produced for the aborted transaction.
REQ-036 Reset SHALL take priority over req and mem_ack on the same edge.

Verification
REQ-037 The bench SHALL cover this read case: req=1, we=0, addr=0x0324; mem_ack=1 with mem_rdata=0xDEADBEEF in the first ACCESS cycle; required response: mem_rd=1 for 1 cycle, done=1 with err=0 two cycles after req, rdata=0xDEADBEEF.
REQ-038 The bench SHALL cover this write case: req=1, we=1, addr=0x4125, wdata=0x12345678; mem_ack after 3 wait cycles; required response: mem_wr=1 for 4 cycles, mem_addr=0x4125, mem_wdata=0x12345678, done with err=0, rdata unchanged.
REQ-039 The bench SHALL cover this timeout case: read of addr=0xFFFF with mem_ack held at 0; required response: mem_rd high for 15 cycles, done=1 with err=1, rdata unchanged, mem_addr=0xFFFF.
REQ-040 The bench SHALL cover this ack-on-last-cycle case: mem_ack=1 on the 15th ACCESS cycle with mem_rdata=0xA5A5A5A5; required response: err=0, rdata=0xA5A5A5A5.
REQ-041 The bench SHALL cover this busy-ignore case: a second req with addr=0x0001 during ACCESS and during RESP; required response: mem_addr stays at the first address, and exactly one done pulse occurs.
REQ-042 The bench SHALL cover this reset-mid-ACCESS case: reset=1 on the 2nd ACCESS cycle; required response: all outputs 0 at that edge, and no done pulse afterwards.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Single-outstanding memory bus controller. A request sampled in IDLE latches
// the address, direction and write data, then the block drives a read or
// write strobe until the memory acknowledges or the wait budget runs out.
// A one-cycle done pulse closes every transaction that was not aborted by reset.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   req        : start a transaction (accepted only in IDLE)
//   we         : 1 = write, 0 = read (sampled with req)
//   addr       : transaction address (sampled with req)
//   wdata      : write data (sampled with req)
//   busy       : high while in ACCESS or RESP
//   done       : one-cycle completion pulse
//   err        : timeout flag, meaningful only while done = 1
//   rdata      : last successfully read word
//   mem_addr   : latched address to memory
//   mem_wdata  : latched write data to memory
//   mem_rd     : read strobe
//   mem_wr     : write strobe
//   mem_rdata  : memory read data, valid with mem_ack
//   mem_ack    : memory completion
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // The counter only needs to reach TIMEOUT-1 (the last permitted cycle).
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_mem_rd;
    logic              w_mem_rd_nxt;
    logic              r_mem_wr;
    logic              w_mem_wr_nxt;
    logic              w_last;

    assign w_last = (r_cnt == CNT_LAST);

    // Next-state, datapath and next-output computation.
    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_mem_addr_nxt  = addr;
                    w_mem_wdata_nxt = wdata;
                    w_we_nxt        = we;
                    w_cnt_nxt       = {CNT_W{1'b0}};
                    w_state_nxt     = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so an ack on the last cycle is a success.
                if (mem_ack) begin
                    w_state_nxt = ST_RESP;
                    if (!r_we) begin
                        w_rdata_nxt = mem_rdata;
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                end else if (w_last) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_done_nxt   = (w_state_nxt == ST_RESP);
        w_mem_rd_nxt = (w_state_nxt == ST_ACCESS) && !w_we_nxt;
        w_mem_wr_nxt = (w_state_nxt == ST_ACCESS) && w_we_nxt;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Transaction-level bench: the driver issues transactions and pushes the
// expected completion into a scoreboard queue; an independent monitor pops
// and compares on every done pulse, and tracks strobe activity in between.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        int            strobes;
        int            issue;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [DW-1:0] m_rdata;   // reference copy of the last successfully read word

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction. ack_at = ACCESS cycle (1-based) on which mem_ack is
    // raised; anything above TO means the memory never answers.
    task automatic do_txn(input logic t_we, input logic [AW-1:0] t_addr,
                          input logic [DW-1:0] t_wdata, input int ack_at,
                          input logic [DW-1:0] t_mrd, input logic spur,
                          input int gap);
        exp_t e;
        int   n_acc;
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; mem_ack = 1'b0;
        tick();
        if (ack_at <= TO) begin
            n_acc = ack_at;
            e.err = 1'b0;
            if (!t_we) m_rdata = t_mrd;
        end else begin
            n_acc = TO;
            e.err = 1'b1;
        end
        e.rdata = m_rdata; e.addr = t_addr; e.wdata = t_wdata; e.we = t_we;
        e.strobes = n_acc; e.issue = cyc;
        sb.push_back(e);
        // Any further request while busy must be ignored.
        req = spur; addr = spur ? 16'h0001 : 16'($urandom);
        we = ~t_we; wdata = $urandom;
        for (int k = 1; k <= n_acc; k++) begin
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? t_mrd : $urandom;
            tick();
        end
        // RESP cycle: stray acks and requests are ignored.
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; req = spur;
        tick();
        req = 1'b0; mem_ack = 1'($urandom_range(0, 1));
        for (int g = 0; g < gap; g++) tick();
        mem_ack = 1'b0;
    endtask

    // Monitor: strobe bookkeeping and scoreboard comparison on each done.
    initial begin
        int   rd_n = 0;
        int   wr_n = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                rd_n = 0; wr_n = 0;
            end else begin
                if (mem_rd) rd_n++;
                if (mem_wr) wr_n++;
                chk("busy_consistent", 128'(busy), 128'(mem_rd | mem_wr | done));
                chk("strobe_exclusive", 128'(mem_rd & mem_wr), 128'(0));
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 128'(1), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("err", 128'(err), 128'(e.err));
                        chk("rdata", 128'(rdata), 128'(e.rdata));
                        chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                        chk("mem_wdata", 128'(mem_wdata), 128'(e.wdata));
                        chk("rd_cycles", 128'(rd_n), 128'(e.we ? 0 : e.strobes));
                        chk("wr_cycles", 128'(wr_n), 128'(e.we ? e.strobes : 0));
                        chk("latency", 128'(cyc - e.issue), 128'(e.strobes));
                    end
                    rd_n = 0; wr_n = 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0; m_rdata = '0;
        tick(); tick();
        chk("reset_state", 128'({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}),
            128'(0));
        reset = 1'b0;
        tick();
        chk("idle_hold", 128'({busy, done, mem_rd, mem_wr, mem_addr}), 128'(0));

        // Directed cases.
        do_txn(1'b0, 16'h0324, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1);
        do_txn(1'b1, 16'h4125, 32'h12345678, 4, 32'h0BAD0BAD, 1'b0, 1);
        do_txn(1'b0, 16'hFFFF, 32'h0, TO + 1, 32'h11111111, 1'b0, 1);
        do_txn(1'b0, 16'h7777, 32'h0, TO, 32'hA5A5A5A5, 1'b0, 1);
        do_txn(1'b1, 16'h2222, 32'hCAFEF00D, 3, 32'h0, 1'b1, 0);
        do_txn(1'b0, 16'h3333, 32'h0, 2, 32'h5A5A5A5A, 1'b1, 0);

        // Reset on the 2nd ACCESS cycle, colliding with req and mem_ack.
        req = 1'b1; we = 1'b0; addr = 16'h1234; wdata = 32'h9;
        tick();
        req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("mid_access_busy", 128'({busy, mem_rd}), 128'(2'b11));
        reset = 1'b1; req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
        tick();
        chk("reset_mid_access", 128'({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}),
            128'(0));
        m_rdata = '0;
        reset = 1'b0; req = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                   int'($urandom_range(1, TO + 1)), $urandom,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
